wishbone_fifo_device: RTL and testbench

Wishbone classic device that exposes a synchronous FIFO behind a data-only bus port. Each controller write cycle pushes one word. Each read cycle pops one word. Overflow and underflow are reported with `err_o` or `rty_o`. It is the device end of the `wishbone_classic` interface: a formal or simulation target for controller-side blocks, and a mailbox between controller subsystems.

---
 rtl/wishbone_fifo_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/wishbone_fifo_device.sv | 101 ++++++++++
 tb/tb_wishbone_fifo_device.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_fifo_pkg.sv
// wishbone_fifo_pkg: shared types for the Wishbone FIFO device.
// Holds the device FSM states and the bus termination outcomes.
package wishbone_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_dev_state_t;

  typedef enum logic [1:0] {
    TERM_ACK,
    TERM_ERR,
    TERM_RTY
  } wb_term_t;

  function automatic wb_term_t fail_term(input bit blocking);
    return blocking ? TERM_RTY : TERM_ERR;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with occupancy count.
// The head word is registered on pop and cleared on every other cycle.
module sync_fifo #(
  parameter int DAT_WIDTH = 8,
  parameter int DEPTH     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DAT_WIDTH-1:0]   dat_i,
  output logic [DAT_WIDTH-1:0]   dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DAT_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [DAT_WIDTH-1:0] r_rdata;
  logic                 w_push;
  logic                 w_pop;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign count_o = r_count;
  assign dat_o   = r_rdata;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      r_rdata <= w_pop ? r_mem[r_rd_ptr] : '0;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wishbone_fifo_device.sv
// wishbone_fifo_device: Wishbone classic device in front of a FIFO.
// Writes push, reads pop; full/empty end the cycle with err or rty.
module wishbone_fifo_device
  import wishbone_fifo_pkg::*;
#(
  parameter int DAT_WIDTH   = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int BLOCKING    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cyc_i,
  input  logic                   stb_i,
  input  logic                   we_i,
  input  logic [DAT_WIDTH-1:0]   dat_i,
  output logic [DAT_WIDTH-1:0]   dat_o,
  output logic                   ack_o,
  output logic                   err_o,
  output logic                   rty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam wb_term_t FAIL_TERM = fail_term(BLOCKING != 0);

  wb_dev_state_t r_state;
  logic [3:0]    r_wait;
  logic          r_ack;
  logic          r_err;
  logic          r_rty;
  logic          w_req;
  logic          w_exec;
  logic          w_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;

  assign w_req  = cyc_i && stb_i;
  assign w_exec = (r_state == IDLE && w_req && WAIT_STATES == 0)
               || (r_state == WAIT && cyc_i && r_wait == '0);
  assign w_ok   = we_i ? !w_full : !w_empty;
  assign w_push = w_exec && we_i && !w_full;
  assign w_pop  = w_exec && !we_i && !w_empty;

  assign ack_o   = r_ack;
  assign err_o   = r_err;
  assign rty_o   = r_rty;
  assign full_o  = w_full;
  assign empty_o = w_empty;

  sync_fifo #(
    .DAT_WIDTH (DAT_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .dat_i   (dat_i),
    .dat_o   (dat_o),
    .count_o (count_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rty   <= 1'b0;
    end else begin
      r_ack <= w_exec && w_ok;
      r_err <= w_exec && !w_ok && FAIL_TERM == TERM_ERR;
      r_rty <= w_exec && !w_ok && FAIL_TERM == TERM_RTY;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_wait  <= WS_LOAD;
            r_state <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          // Controller gave up: drop the request silently
          if (!cyc_i)              r_state <= IDLE;
          else if (r_wait == '0)   r_state <= RESP;
          else                     r_wait  <= r_wait - 4'd1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_fifo_device.sv
// tb_wishbone_fifo_device: scoreboard bench over three device configs.
// dut0 plain err mode, dut1 three wait states, dut2 retry mode.
module tb_wishbone_fifo_device;

  typedef struct {
    bit         we;
    logic [2:0] term;
    logic [7:0] dat;
    int         cnt;
    int         lat;
    int         issue;
  } exp_t;

  localparam logic [2:0] T_ACK = 3'b001;
  localparam logic [2:0] T_ERR = 3'b010;
  localparam logic [2:0] T_RTY = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cyc = 1'b0;
  logic       stb = 1'b0;
  logic       we  = 1'b0;
  logic [7:0] dat = '0;
  int         sel = 0;

  logic [2:0] ack_v, err_v, rty_v, full_v, empty_v;
  logic [7:0] dat_v [3];
  logic [2:0] cnt_v [3];

  logic [2:0] w_term;
  logic [7:0] w_dat;
  logic [2:0] w_cnt;
  logic       w_full, w_empty;

  exp_t       sbq[$];
  logic [7:0] mdl[$];
  exp_t       m_e;
  bit         prev_rd = 0;
  int         cyc_cnt = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wishbone_fifo_device #(
      .DAT_WIDTH   (8),
      .DEPTH       (4),
      .WAIT_STATES (g == 1 ? 3 : 0),
      .BLOCKING    (g == 2 ? 1 : 0)
    ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .cyc_i   (cyc && sel == g),
      .stb_i   (stb),
      .we_i    (we),
      .dat_i   (dat),
      .dat_o   (dat_v[g]),
      .ack_o   (ack_v[g]),
      .err_o   (err_v[g]),
      .rty_o   (rty_v[g]),
      .count_o (cnt_v[g]),
      .full_o  (full_v[g]),
      .empty_o (empty_v[g])
    );
  end

  assign w_term  = {rty_v[sel], err_v[sel], ack_v[sel]};
  assign w_dat   = dat_v[sel];
  assign w_cnt   = cnt_v[sel];
  assign w_full  = full_v[sel];
  assign w_empty = empty_v[sel];

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Monitor: every termination pops one expected response
  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 0;
    end else begin
      if (prev_rd) chk("dat_clr", {24'd0, w_dat}, 0);
      prev_rd = 0;
      if (w_term != 3'b000) begin
        if (sbq.size() == 0) begin
          chk("unexpected", {29'd0, w_term}, 0);
        end else begin
          m_e = sbq.pop_front();
          chk("term", {29'd0, w_term}, {29'd0, m_e.term});
          chk("lat", cyc_cnt - m_e.issue, m_e.lat);
          chk("count", {29'd0, w_cnt}, m_e.cnt);
          chk("full", {31'd0, w_full}, {31'd0, m_e.cnt == 4});
          chk("empty", {31'd0, w_empty}, {31'd0, m_e.cnt == 0});
          if (!m_e.we) begin
            chk("rdata", {24'd0, w_dat}, {24'd0, m_e.dat});
            prev_rd = (w_term == T_ACK);
          end
        end
      end
    end
  end

  task automatic xfer(input bit w, input logic [7:0] d, input bit hold);
    exp_t e;
    e.we  = w;
    e.dat = '0;
    if (w) begin
      if (mdl.size() < 4) begin
        mdl.push_back(d);
        e.term = T_ACK;
      end else begin
        e.term = (sel == 2) ? T_RTY : T_ERR;
      end
    end else begin
      if (mdl.size() > 0) begin
        e.dat  = mdl.pop_front();
        e.term = T_ACK;
      end else begin
        e.term = (sel == 2) ? T_RTY : T_ERR;
      end
    end
    e.cnt   = mdl.size();
    e.lat   = (sel == 1) ? 4 : 1;
    e.issue = cyc_cnt;
    sbq.push_back(e);
    cyc = 1'b1;
    stb = 1'b1;
    we  = w;
    dat = d;
    for (int n = 0; n < 20 && sbq.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    if (sbq.size() != 0) begin
      chk("timeout", sbq.size(), 0);
      sbq.delete();
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      cyc = 1'b0;
      stb = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", {29'd0, w_cnt}, 0);
    chk("rst_empty", {31'd0, w_empty}, 1);
    chk("rst_full", {31'd0, w_full}, 0);
    chk("rst_term", {29'd0, w_term}, 0);
    chk("rst_dat", {24'd0, w_dat}, 0);
    idle(1);

    // dut0: write/read, overflow, underflow, wrap with held request
    sel = 0;
    xfer(1'b1, 8'hA5, 1'b0);
    xfer(1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) xfer(1'b1, 8'(i), 1'b0);
    for (int i = 1; i <= 5; i++) xfer(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++)
      xfer((i % 2) == 0, 8'(8'h10 + i), i < 9);
    idle(2);

    // dut2: retry mode
    sel = 2;
    mdl.delete();
    xfer(1'b0, 8'h00, 1'b0);
    idle(2);
    xfer(1'b1, 8'h5A, 1'b0);
    xfer(1'b0, 8'h00, 1'b0);
    idle(2);

    // dut1: wait states, abandoned request, reset during WAIT
    sel = 1;
    mdl.delete();
    xfer(1'b1, 8'h33, 1'b0);
    xfer(1'b1, 8'h44, 1'b0);
    cyc = 1'b1;
    stb = 1'b1;
    we  = 1'b0;
    idle(2);
    cyc = 1'b0;
    stb = 1'b0;
    idle(6);
    chk("abandon_cnt", {29'd0, w_cnt}, 2);
    chk("abandon_empty", {31'd0, w_empty}, 0);

    cyc = 1'b1;
    stb = 1'b1;
    we  = 1'b0;
    idle(1);
    rst = 1'b1;
    cyc = 1'b0;
    stb = 1'b0;
    idle(1);
    rst = 1'b0;
    mdl.delete();
    @(negedge clk);
    chk("inflt_count", {29'd0, w_cnt}, 0);
    chk("inflt_empty", {31'd0, w_empty}, 1);
    chk("inflt_full", {31'd0, w_full}, 0);
    chk("inflt_term", {29'd0, w_term}, 0);
    chk("inflt_dat", {24'd0, w_dat}, 0);
    idle(1);
    xfer(1'b0, 8'h00, 1'b0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
